// File: rtl/snitch_motion_scheduler_pkg.sv
// rtl/snitch_motion_scheduler_pkg.sv - shared state encoding, LFSR taps and arena defaults
package snitch_motion_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ROAM    = 2'd1,
        ST_CAUGHT  = 2'd2,
        ST_RESPAWN = 2'd3
    } snitch_state_e;

    // x^8 + x^6 + x^5 + x^4 + 1, shift-left Fibonacci form
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam int DEF_TICK_DIV      = 10000000;
    localparam int DEF_STEP          = 10;
    localparam int DEF_X_MIN         = 120;
    localparam int DEF_X_MAX         = 420;
    localparam int DEF_Y_MIN         = 40;
    localparam int DEF_Y_MAX         = 340;
    localparam int DEF_SPRITE        = 100;
    localparam int DEF_RESPAWN_TICKS = 30;
    localparam logic [7:0] DEF_LFSR_SEED = 8'hA5;

    function automatic logic [7:0] lfsr_advance(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/snitch_motion_scheduler_tick_gen.sv
// rtl/snitch_motion_scheduler_tick_gen.sv - clock divider producing a one-cycle movement tick
module snitch_motion_scheduler_tick_gen #(
    parameter int TICK_DIV = 10000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] r_count;
    logic          w_last;

    assign w_last = (r_count == CW'(TICK_DIV - 1));
    // a clear in the terminal cycle suppresses the tick so nothing moves on exit
    assign o_tick = w_last && !i_clear;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear || w_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/snitch_motion_scheduler.sv
// rtl/snitch_motion_scheduler.sv - golden-snitch roam / catch / respawn sequencer
module snitch_motion_scheduler
    import snitch_motion_scheduler_pkg::*;
#(
    parameter int         TICK_DIV      = DEF_TICK_DIV,
    parameter int         STEP          = DEF_STEP,
    parameter int         X_MIN         = DEF_X_MIN,
    parameter int         X_MAX         = DEF_X_MAX,
    parameter int         Y_MIN         = DEF_Y_MIN,
    parameter int         Y_MAX         = DEF_Y_MAX,
    parameter int         SPRITE        = DEF_SPRITE,
    parameter int         RESPAWN_TICKS = DEF_RESPAWN_TICKS,
    parameter logic [7:0] LFSR_SEED     = DEF_LFSR_SEED
) (
    input  logic       i_clk,
    input  logic       i_resetn,
    input  logic       i_powerup,
    input  logic [8:0] i_player_row,
    input  logic [9:0] i_player_col,
    output logic [8:0] o_snitch_row,
    output logic [9:0] o_snitch_col,
    output logic       o_visible,
    output logic       o_caught_pulse,
    output logic [7:0] o_score
);

    localparam int RW = $clog2(RESPAWN_TICKS + 1);
    localparam logic [10:0] C_X_MIN  = 11'(X_MIN);
    localparam logic [10:0] C_X_MAX  = 11'(X_MAX);
    localparam logic [10:0] C_Y_MIN  = 11'(Y_MIN);
    localparam logic [10:0] C_Y_MAX  = 11'(Y_MAX);
    localparam logic [10:0] C_STEP   = 11'(STEP);
    localparam logic [10:0] C_SPRITE = 11'(SPRITE);

    snitch_state_e r_state, w_state;
    logic [8:0]    r_row, w_row;
    logic [9:0]    r_col, w_col;
    logic          r_visible, w_visible;
    logic          r_pulse, w_pulse;
    logic [7:0]    r_score, w_score;
    logic [7:0]    r_lfsr, w_lfsr;
    logic          r_dir_x, w_dir_x;
    logic          r_dir_y, w_dir_y;
    logic [RW-1:0] r_resp, w_resp;

    logic          w_tick, w_tick_clr, w_hit;
    logic [10:0]   w_col_ext, w_row_ext, w_pcol_ext, w_prow_ext;
    logic [10:0]   w_rsp_col_raw, w_rsp_row_raw, w_rsp_col, w_rsp_row;

    assign w_tick_clr = (r_state == ST_IDLE) || !i_powerup;

    snitch_motion_scheduler_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .i_clk   (i_clk),
        .i_rst_n (i_resetn),
        .i_clear (w_tick_clr),
        .o_tick  (w_tick)
    );

    assign w_col_ext  = {1'b0, r_col};
    assign w_row_ext  = {2'b0, r_row};
    assign w_pcol_ext = {1'b0, i_player_col};
    assign w_prow_ext = {2'b0, i_player_row};

    assign w_hit = (w_pcol_ext >= w_col_ext) && (w_pcol_ext < w_col_ext + C_SPRITE) &&
                   (w_prow_ext >= w_row_ext) && (w_prow_ext < w_row_ext + C_SPRITE);

    assign w_rsp_col_raw = C_X_MIN + 11'(r_lfsr[7:4]) * C_STEP;
    assign w_rsp_row_raw = C_Y_MIN + 11'(r_lfsr[3:0]) * C_STEP;
    assign w_rsp_col     = (w_rsp_col_raw > C_X_MAX) ? C_X_MAX : w_rsp_col_raw;
    assign w_rsp_row     = (w_rsp_row_raw > C_Y_MAX) ? C_Y_MAX : w_rsp_row_raw;

    always_comb begin
        w_state   = r_state;
        w_row     = r_row;
        w_col     = r_col;
        w_visible = r_visible;
        w_pulse   = 1'b0;
        w_score   = r_score;
        w_lfsr    = w_tick ? lfsr_advance(r_lfsr) : r_lfsr;
        w_dir_x   = r_dir_x;
        w_dir_y   = r_dir_y;
        w_resp    = r_resp;

        if (r_state == ST_IDLE) begin
            if (i_powerup) begin
                w_state   = ST_ROAM;
                w_visible = 1'b1;
            end
        end else if (!i_powerup) begin
            w_state   = ST_IDLE;
            w_visible = 1'b0;
            w_resp    = '0;
        end else begin
            case (r_state)
                ST_ROAM: begin
                    if (w_hit) begin
                        w_state   = ST_CAUGHT;
                        w_pulse   = 1'b1;
                        w_visible = 1'b0;
                        w_score   = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
                    end else if (w_tick) begin
                        // random flip uses the pre-advance LFSR, bounce reverses after it
                        w_dir_x = r_dir_x ^ (r_lfsr[1:0] == 2'b00);
                        w_dir_y = r_dir_y ^ (r_lfsr[3:2] == 2'b00);
                        if (w_dir_x) begin
                            if (w_col_ext + C_STEP > C_X_MAX) begin
                                w_col   = 10'(C_X_MAX);
                                w_dir_x = 1'b0;
                            end else begin
                                w_col = 10'(w_col_ext + C_STEP);
                            end
                        end else if (w_col_ext < C_X_MIN + C_STEP) begin
                            w_col   = 10'(C_X_MIN);
                            w_dir_x = 1'b1;
                        end else begin
                            w_col = 10'(w_col_ext - C_STEP);
                        end
                        if (w_dir_y) begin
                            if (w_row_ext + C_STEP > C_Y_MAX) begin
                                w_row   = 9'(C_Y_MAX);
                                w_dir_y = 1'b0;
                            end else begin
                                w_row = 9'(w_row_ext + C_STEP);
                            end
                        end else if (w_row_ext < C_Y_MIN + C_STEP) begin
                            w_row   = 9'(C_Y_MIN);
                            w_dir_y = 1'b1;
                        end else begin
                            w_row = 9'(w_row_ext - C_STEP);
                        end
                    end
                end
                ST_CAUGHT: begin
                    w_state = ST_RESPAWN;
                    w_resp  = '0;
                end
                default: begin
                    if (w_tick) begin
                        if (r_resp == RW'(RESPAWN_TICKS - 1)) begin
                            w_col     = 10'(w_rsp_col);
                            w_row     = 9'(w_rsp_row);
                            w_visible = 1'b1;
                            w_state   = ST_ROAM;
                        end else begin
                            w_resp = r_resp + RW'(1);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state   <= ST_IDLE;
            r_row     <= 9'(Y_MIN);
            r_col     <= 10'(X_MIN);
            r_visible <= 1'b0;
            r_pulse   <= 1'b0;
            r_score   <= 8'd0;
            r_lfsr    <= LFSR_SEED;
            r_dir_x   <= 1'b1;
            r_dir_y   <= 1'b1;
            r_resp    <= '0;
        end else begin
            r_state   <= w_state;
            r_row     <= w_row;
            r_col     <= w_col;
            r_visible <= w_visible;
            r_pulse   <= w_pulse;
            r_score   <= w_score;
            r_lfsr    <= w_lfsr;
            r_dir_x   <= w_dir_x;
            r_dir_y   <= w_dir_y;
            r_resp    <= w_resp;
        end
    end

    assign o_snitch_row   = r_row;
    assign o_snitch_col   = r_col;
    assign o_visible      = r_visible;
    assign o_caught_pulse = r_pulse;
    assign o_score        = r_score;

endmodule

// File: tb/tb_snitch_motion_scheduler.sv
// tb/tb_snitch_motion_scheduler.sv - randomized bench with behavioural snitch model
module tb_snitch_motion_scheduler;

    localparam int TDIV = 4;
    localparam int RT   = 3;
    localparam int STEP = 10;
    localparam int XMIN = 120;
    localparam int XMAX = 420;
    localparam int YMIN = 40;
    localparam int YMAX = 340;
    localparam int SPR  = 100;

    localparam int P_IDLE = 0, P_ROAM = 1, P_CAUGHT = 2, P_RESP = 3;

    logic       clk = 1'b0;
    logic       rstn;
    logic       pu;
    logic [8:0] prow;
    logic [9:0] pcol;
    logic [8:0] o_snitch_row;
    logic [9:0] o_snitch_col;
    logic       o_visible, o_caught_pulse;
    logic [7:0] o_score;

    int n_checks = 0;
    int n_errors = 0;

    int m_ph, m_cnt, m_lfsr, m_dx, m_dy, m_x, m_y, m_vis, m_pulse, m_score, m_resp;

    always #5 clk = ~clk;

    snitch_motion_scheduler #(
        .TICK_DIV      (TDIV),
        .RESPAWN_TICKS (RT)
    ) dut (
        .i_clk          (clk),
        .i_resetn       (rstn),
        .i_powerup      (pu),
        .i_player_row   (prow),
        .i_player_col   (pcol),
        .o_snitch_row   (o_snitch_row),
        .o_snitch_col   (o_snitch_col),
        .o_visible      (o_visible),
        .o_caught_pulse (o_caught_pulse),
        .o_score        (o_score)
    );

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic int lfsr_next(input int v);
        int fb;
        fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
        return ((v << 1) & 255) | fb;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m_ph = P_IDLE; m_cnt = 0; m_lfsr = 'hA5; m_dx = 1; m_dy = 1;
        m_x = XMIN; m_y = YMIN; m_vis = 0; m_pulse = 0; m_score = 0; m_resp = 0;
    endtask

    task automatic model_step(input bit p, input int pr, input int pc);
        int old, nx, ny;
        bit tk;
        old = m_lfsr;
        m_pulse = 0;
        if (m_ph == P_IDLE) begin
            if (p) begin
                m_ph = P_ROAM; m_vis = 1;
            end
        end else if (!p) begin
            m_ph = P_IDLE; m_cnt = 0; m_resp = 0; m_vis = 0;
        end else begin
            tk = (m_cnt == TDIV - 1);
            m_cnt = tk ? 0 : m_cnt + 1;
            if (tk) m_lfsr = lfsr_next(old);
            case (m_ph)
                P_ROAM: begin
                    if (pc >= m_x && pc < m_x + SPR && pr >= m_y && pr < m_y + SPR) begin
                        m_ph = P_CAUGHT; m_pulse = 1; m_vis = 0;
                        if (m_score < 255) m_score++;
                    end else if (tk) begin
                        if (old % 4 == 0) m_dx = -m_dx;
                        if ((old / 4) % 4 == 0) m_dy = -m_dy;
                        nx = m_x + m_dx * STEP;
                        ny = m_y + m_dy * STEP;
                        if (nx > XMAX) begin nx = XMAX; m_dx = -1; end
                        else if (nx < XMIN) begin nx = XMIN; m_dx = 1; end
                        if (ny > YMAX) begin ny = YMAX; m_dy = -1; end
                        else if (ny < YMIN) begin ny = YMIN; m_dy = 1; end
                        m_x = nx; m_y = ny;
                    end
                end
                P_CAUGHT: begin
                    m_ph = P_RESP; m_resp = 0;
                end
                default: begin
                    if (tk) begin
                        if (m_resp == RT - 1) begin
                            m_x = imin(XMIN + (old / 16) * STEP, XMAX);
                            m_y = imin(YMIN + (old % 16) * STEP, YMAX);
                            m_vis = 1; m_ph = P_ROAM;
                        end else begin
                            m_resp++;
                        end
                    end
                end
            endcase
        end
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, "_row"},   int'(o_snitch_row),   m_y);
        check_eq({tag, "_col"},   int'(o_snitch_col),   m_x);
        check_eq({tag, "_vis"},   int'(o_visible),      m_vis);
        check_eq({tag, "_pulse"}, int'(o_caught_pulse), m_pulse);
        check_eq({tag, "_score"}, int'(o_score),        m_score);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rstn) model_reset();
        else model_step(pu, int'(prow), int'(pcol));
        #1;
        compare_all("cyc");
    endtask

    task automatic player_far();
        prow = 9'd511;
        pcol = 10'd1023;
    endtask

    task automatic player_on_sprite();
        prow = 9'(m_y + $urandom_range(0, SPR - 1));
        pcol = 10'(m_x + $urandom_range(0, SPR - 1));
    endtask

    initial begin
        int s0, mp, dp, found;
        rstn = 1'b0; pu = 1'b0;
        player_far();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        rstn = 1'b1;

        pu = 1'b1;
        cycle();
        check_eq("vis_after_powerup", int'(o_visible), 1);
        repeat (4) cycle();
        check_eq("first_tick_row", int'(o_snitch_row), 50);
        check_eq("first_tick_col", int'(o_snitch_col), 130);

        // long free roam exercises bounces on every wall
        repeat (800) cycle();

        // boundary of the catch box: one row below misses, far corner hits
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (m_ph == P_ROAM && m_cnt != TDIV - 1) found = 1;
            else cycle();
        end
        check_eq("wait_roam_catch", found, 1);
        s0 = m_score;
        prow = 9'(m_y + SPR); pcol = 10'(m_x);
        cycle();
        check_eq("edge_no_catch", int'(o_caught_pulse), 0);
        prow = 9'(m_y + SPR - 1); pcol = 10'(m_x + SPR - 1);
        cycle();
        check_eq("corner_catch_pulse", int'(o_caught_pulse), 1);
        check_eq("corner_catch_score", int'(o_score), s0 + 1);
        check_eq("corner_catch_vis", int'(o_visible), 0);
        player_far();
        cycle();
        check_eq("pulse_one_cycle", int'(o_caught_pulse), 0);
        for (int i = 0; i < 100 && m_vis == 0; i++) cycle();
        check_eq("respawn_visible", int'(o_visible), 1);

        // random mix of player positions and brief powerup drops
        for (int i = 0; i < 3000; i++) begin
            pu = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 9) < 3) player_on_sprite();
            else if ($urandom_range(0, 1) == 0) player_far();
            else begin
                prow = 9'($urandom_range(0, 511));
                pcol = 10'($urandom_range(0, 1023));
            end
            cycle();
        end

        // saturation run: player sits on the sprite continuously
        pu = 1'b1;
        mp = 0; dp = 0;
        for (int i = 0; i < 20000 && mp < 300; i++) begin
            player_on_sprite();
            cycle();
            if (m_pulse == 1) mp++;
            if (o_caught_pulse) dp++;
        end
        check_eq("catch_budget", (mp >= 300) ? 1 : 0, 1);
        check_eq("pulse_count", dp, mp);
        check_eq("score_saturated", int'(o_score), 255);

        // powerup drop while roaming
        player_far();
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (m_ph == P_ROAM) found = 1;
            else cycle();
        end
        check_eq("wait_roam_drop", found, 1);
        pu = 1'b0;
        cycle();
        check_eq("drop_vis", int'(o_visible), 0);
        check_eq("drop_pulse", int'(o_caught_pulse), 0);
        check_eq("drop_score", int'(o_score), 255);
        repeat (3) cycle();
        pu = 1'b1;
        repeat (6) cycle();

        // asynchronous reset in the middle of respawn
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (m_ph == P_RESP) found = 1;
            else begin
                player_on_sprite();
                cycle();
            end
        end
        check_eq("wait_respawn", found, 1);
        player_far();
        rstn = 1'b0;
        #1;
        model_reset();
        compare_all("async_reset");
        cycle();
        rstn = 1'b1;
        repeat (10) cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
